// File: rtl/pri_arbiter_n.sv
// pri_arbiter_n: N-input fixed/round-robin priority arbiter with registered grant and ack handshake
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   en         : arbiter enable
//   mode       : 0 = fixed priority (highest index wins), 1 = round-robin from ptr
//   req        : request vector, bit i = channel i requesting
//   ack        : consumer accepts the current grant
//   idc        : combinational en && |req
//   gnt_vld    : grant valid
//   gnt_idx    : index of granted channel, kept while gnt_vld=0
//   gnt_onehot : one-hot of gnt_idx, zero while gnt_vld=0
module pri_arbiter_n #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         idc,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);
    localparam logic [W:0]   NN   = (W+1)'(N);
    localparam logic [W-1:0] LAST = W'(N - 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t       state, state_nx;
    logic [W-1:0] ptr, win, fix, off;
    logic [N-1:0] rot;
    logic [W:0]   sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && idc) gnt_idx <= win;
            if (state == GRANT && ack) ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + W'(1);
        end
    end
    always_comb state_nx = (state == IDLE) ? (idc ? GRANT : IDLE) : ((ack || !en) ? IDLE : GRANT);
    // Rotating a doubled copy right by ptr puts channel (ptr+k) mod N at bit k, so the
    // lowest set bit of rot is the round-robin winner's offset from ptr.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        fix = '0;
        for (int k = N - 1; k >= 0; k--) if (rot[k]) off = W'(k);
        for (int i = 0; i < N; i++) if (req[i]) fix = W'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        win = mode ? ((sum >= NN) ? W'(sum - NN) : W'(sum)) : fix;
    end
    always_comb begin
        idc        = en && (req != '0);
        gnt_vld    = (state == GRANT);
        gnt_onehot = gnt_vld ? (N'(1) << gnt_idx) : '0;
    end
endmodule

// File: tb/tb_pri_arbiter_n.sv
// tb_pri_arbiter_n: table-driven scoreboard bench for pri_arbiter_n at N=8 and N=5
module tb_pri_arbiter_n;
    logic       clk = 0;
    logic       rst8 = 1, en8 = 1, mode8 = 0, ack8 = 0;
    logic [7:0] req8 = 8'hFF;
    logic       idc8, vld8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic       rst5 = 1, en5 = 1, mode5 = 0, ack5 = 0;
    logic [4:0] req5 = '0;
    logic       idc5, vld5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, en, mode;
        logic [7:0] req;
        logic       ack, vld;
        logic [2:0] idx;
    } vec_t;
    typedef struct {
        logic       vld;
        logic [2:0] idx;
        logic [7:0] oh;
    } exp_t;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pri_arbiter_n #(.N(8)) dut8 (.clk(clk), .rst(rst8), .en(en8), .mode(mode8), .req(req8),
        .ack(ack8), .idc(idc8), .gnt_vld(vld8), .gnt_idx(idx8), .gnt_onehot(oh8));
    pri_arbiter_n #(.N(5)) dut5 (.clk(clk), .rst(rst5), .en(en5), .mode(mode5), .req(req5),
        .ack(ack5), .idc(idc5), .gnt_vld(vld5), .gnt_idx(idx5), .gnt_onehot(oh5));

    task automatic check(string name, int step, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic add(logic r, logic e, logic m, logic [7:0] rq, logic a, logic v, logic [2:0] i);
        tbl.push_back('{r, e, m, rq, a, v, i});
    endtask

    // Drive one cycle on the selected instance, check idc, then check registered outputs after the edge.
    task automatic drive(bit five, int step, vec_t t);
        exp_t x;
        logic exp_idc;
        if (five) begin
            rst5 = t.rst; en5 = t.en; mode5 = t.mode; req5 = t.req[4:0]; ack5 = t.ack;
            exp_idc = t.en && (t.req[4:0] != 0);
        end else begin
            rst8 = t.rst; en8 = t.en; mode8 = t.mode; req8 = t.req; ack8 = t.ack;
            exp_idc = t.en && (t.req != 0);
        end
        sb.push_back('{t.vld, t.idx, t.vld ? (8'd1 << t.idx) : 8'd0});
        #1;
        check("idc", step, five ? idc5 : idc8, exp_idc);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("gnt_vld", step, five ? vld5 : vld8, x.vld);
        check("gnt_idx", step, five ? idx5 : idx8, x.idx);
        check("gnt_onehot", step, five ? {3'b0, oh5} : oh8, x.oh);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        add(1,1,0,8'hFF,0, 0,0);
        add(1,1,0,8'hFF,0, 0,0);
        add(0,1,0,8'hFF,0, 1,7);
        add(0,1,0,8'hFF,1, 0,7);
        add(1,1,1,8'hFF,0, 0,0);
        add(0,1,1,8'hFF,0, 1,0);
        add(0,1,1,8'hFF,1, 0,0);
        add(0,1,0,8'h26,0, 1,5);
        add(0,1,0,8'h26,0, 1,5);
        add(0,1,1,8'h26,0, 1,5);
        add(0,1,1,8'h01,0, 1,5);
        add(0,1,0,8'h26,0, 1,5);
        add(0,1,0,8'h26,0, 1,5);
        add(0,1,0,8'h26,1, 0,5);
        add(0,1,0,8'h26,0, 1,5);
        add(0,1,0,8'h26,1, 0,5);
        add(0,1,1,8'h05,0, 1,0);
        add(0,1,1,8'h05,1, 0,0);
        add(0,1,1,8'h05,0, 1,2);
        add(0,1,1,8'h00,0, 1,2);
        add(0,1,1,8'h00,0, 1,2);
        add(0,1,1,8'h00,1, 0,2);
        add(0,0,1,8'hFF,0, 0,2);
        add(0,1,0,8'h08,0, 1,3);
        add(0,0,0,8'h08,0, 0,3);
        add(0,1,1,8'hFF,0, 1,3);
        add(0,1,1,8'hFF,1, 0,3);
        add(0,1,1,8'hFF,1, 1,4);
        add(0,0,1,8'hFF,1, 0,4);
        add(0,1,1,8'hFF,0, 1,5);
        add(1,1,1,8'hFF,0, 0,0);
        add(0,1,1,8'hFF,0, 1,0);
        add(1,0,1,8'hFF,0, 0,0);
        foreach (tbl[s]) drive(0, s, tbl[s]);
        // Round-robin sweep with req all ones: 0..7 then wrap to 0, one bubble per grant.
        for (int k = 0; k < 9; k++) begin
            drive(0, 100 + 2*k, '{0, 1, 1, 8'hFF, 0, 1, 3'(k % 8)});
            drive(0, 101 + 2*k, '{0, 1, 1, 8'hFF, 1, 0, 3'(k % 8)});
        end
        // N=5: pointer wraps from 4 to 0 in round-robin; fixed mode always picks 4.
        drive(1, 200, '{1, 1, 1, 8'h11, 0, 0, 0});
        drive(1, 201, '{0, 1, 1, 8'h11, 0, 1, 0});
        drive(1, 202, '{0, 1, 1, 8'h11, 1, 0, 0});
        drive(1, 203, '{0, 1, 1, 8'h11, 0, 1, 4});
        drive(1, 204, '{0, 1, 1, 8'h11, 1, 0, 4});
        drive(1, 205, '{0, 1, 1, 8'h11, 0, 1, 0});
        drive(1, 206, '{0, 1, 1, 8'h11, 1, 0, 0});
        drive(1, 207, '{0, 1, 0, 8'h11, 0, 1, 4});
        drive(1, 208, '{0, 1, 0, 8'h11, 1, 0, 4});
        drive(1, 209, '{0, 1, 0, 8'h11, 0, 1, 4});
        drive(1, 210, '{0, 1, 1, 8'h1F, 1, 0, 4});
        drive(1, 211, '{0, 1, 1, 8'h1F, 0, 1, 0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
